// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues sequential ROM reads, buffers returned
// instructions with their addresses, and hands them to decode on valid/ready.
module inst_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              started;
  logic              inflight;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] infl_addr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit;
  logic              push;
  logic              pop;
  logic              jump_addr_unused;
  entry_t            mem [DEPTH];

  // Jump targets are forced word-aligned, so the low bits are dropped.
  assign jump_addr_unused = ^jump_addr[1:0];

  // Credits cover both buffered entries and the read in flight, so a push
  // can never land on a full FIFO.
  assign credit     = {1'b0, count} + (CNT_W+1)'(inflight);
  assign rom_req    = started & ~jump_en & (credit < DEPTH_C);
  assign rom_addr   = pc;
  assign push       = inflight & ~jump_en;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready & ~jump_en;

  assign inst_o      = inst_valid ? mem[rd_ptr].data : '0;
  assign inst_addr_o = inst_valid ? mem[rd_ptr].addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started   <= 1'b0;
      inflight  <= 1'b0;
      pc        <= RESET_PC;
      infl_addr <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      started  <= 1'b1;
      inflight <= rom_req;
      if (rom_req) infl_addr <= pc;
      if (jump_en) begin
        pc     <= {jump_addr[ADDR_W-1:2], 2'b00};
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (rom_req) pc <= pc + ADDR_W'(4);
        rd_ptr <= rd_ptr + PTR_W'(pop);
        wr_ptr <= wr_ptr + PTR_W'(push);
        count  <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Storage needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: infl_addr, data: rom_rdata};
  end

endmodule
